// File: rtl/io_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : io_conditioner
// Description : N-channel board input conditioner. For each channel it fixes
//               the pad polarity, synchronises the level, debounces it and
//               produces registered edge pulses. Each channel also has a
//               sticky interrupt-pending bit with enable and acknowledge.
//               The block also generates the SoC reset, which asserts
//               asynchronously and releases synchronously.
// Ports       : clk            - system clock
//               rst            - asynchronous active-high reset
//               raw_in_i       - raw pad levels
//               irq_en_i       - per-channel interrupt enable
//               irq_ack_i      - per-channel pending clear (level, per clk)
//               level_out_o    - debounced active-high level
//               rise_pulse_o   - one-cycle pulse after debounced 0->1
//               fall_pulse_o   - one-cycle pulse after debounced 1->0
//               irq_pend_o     - sticky pending bits
//               irq_any_o      - OR of irq_pend_o
//               sys_resetn_o   - active-low SoC reset
// Options     : IO_COND_BOTH_EDGES_EN - when defined, pending bits are set by
//               both rise and fall pulses. Otherwise only rise pulses set
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
module io_conditioner #(
  parameter int               NCH             = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 250000,
  parameter logic [NCH-1:0]   ACTIVE_LOW_MASK = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] raw_in_i,
  input  logic [NCH-1:0] irq_en_i,
  input  logic [NCH-1:0] irq_ack_i,
  output logic [NCH-1:0] level_out_o,
  output logic [NCH-1:0] rise_pulse_o,
  output logic [NCH-1:0] fall_pulse_o,
  output logic [NCH-1:0] irq_pend_o,
  output logic           irq_any_o,
  output logic           sys_resetn_o
);

  localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Polarity is corrected before the first synchroniser flop. As a result,
  // the all-zero reset state means "inactive" on every channel.
  logic [NCH-1:0] norm;
  assign norm = raw_in_i ^ ACTIVE_LOW_MASK;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   level_dly_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   evt;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Any cycle that agrees with the accepted level restarts the count. This
    // way only an unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync_lvl == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == c_cnt_last) begin
        level_d = sync_lvl;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

`ifdef IO_COND_BOTH_EDGES_EN
    assign evt = rise_q | fall_q;
`else
    assign evt = rise_q;
`endif

    // When an event and an acknowledge arrive together, the set wins.
    // This ensures a fresh event is never lost.
    always_comb begin
      pend_d = pend_q;
      if (evt && irq_en_i[g]) begin
        pend_d = 1'b1;
      end else if (irq_ack_i[g]) begin
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q      <= '0;
        cnt_q       <= '0;
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
        rise_q      <= 1'b0;
        fall_q      <= 1'b0;
        pend_q      <= 1'b0;
      end else begin
        sync_q      <= {sync_q[SYNC_STAGES-2:0], norm[g]};
        cnt_q       <= cnt_d;
        level_q     <= level_d;
        // The edge pulses compare against a delayed copy of the level.
        // Each pulse therefore lands in the cycle after the level changed.
        level_dly_q <= level_q;
        rise_q      <= level_q & ~level_dly_q;
        fall_q      <= ~level_q & level_dly_q;
        pend_q      <= pend_d;
      end
    end

    assign level_out_o[g]  = level_q;
    assign rise_pulse_o[g] = rise_q;
    assign fall_pulse_o[g] = fall_q;
    assign irq_pend_o[g]   = pend_q;
  end

  assign irq_any_o = |irq_pend_o;

  // SoC reset: rst clears the chain at once. Ones then shift in, and release
  // comes on the SYNC_STAGES-th rising edge after rst drops.
  logic [SYNC_STAGES-1:0] rst_chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_chain_q <= '0;
    end else begin
      rst_chain_q <= {rst_chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sys_resetn_o = rst_chain_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_io_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_conditioner
// Description : Directed self-checking bench for io_conditioner.
//               Configuration: NCH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
//               and channel 0 active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] raw_in;
  logic [3:0] irq_en;
  logic [3:0] irq_ack;
  logic [3:0] level_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] irq_pend;
  logic       irq_any;
  logic       sys_resetn;

  int total;
  int bad;

  io_conditioner #(
    .NCH             (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW_MASK (4'b0001)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in_i     (raw_in),
    .irq_en_i     (irq_en),
    .irq_ack_i    (irq_ack),
    .level_out_o  (level_out),
    .rise_pulse_o (rise_pulse),
    .fall_pulse_o (fall_pulse),
    .irq_pend_o   (irq_pend),
    .irq_any_o    (irq_any),
    .sys_resetn_o (sys_resetn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle. Inputs change and outputs are
  // sampled here, 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    raw_in  = 4'b0001;
    irq_en  = 4'b0010;
    irq_ack = 4'b0000;
    repeat (3) tick();
    total++; if (level_out !== 4'b0000) begin bad++; $display("FAIL reset_level got=%b exp=%b", level_out, 4'b0000); end
    total++; if (rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin bad++; $display("FAIL reset_pulses got=%b/%b exp=0000/0000", rise_pulse, fall_pulse); end
    total++; if (irq_pend !== 4'b0000 || irq_any !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b/%b exp=0000/0", irq_pend, irq_any); end
    total++; if (sys_resetn !== 1'b0) begin bad++; $display("FAIL reset_sysrn got=%b exp=0", sys_resetn); end
    rst = 1'b0;
    tick();
    total++; if (sys_resetn !== 1'b0) begin bad++; $display("FAIL sysrn_k1 got=%b exp=0", sys_resetn); end
    tick();
    total++; if (sys_resetn !== 1'b1) begin bad++; $display("FAIL sysrn_k2 got=%b exp=1", sys_resetn); end
    repeat (6) tick();
    total++; if (level_out !== 4'b0000) begin bad++; $display("FAIL idle_level got=%b exp=%b", level_out, 4'b0000); end
  endtask

  task automatic test_press();
    raw_in[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (level_out !== ((i >= 6) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL press_level c%0d got=%b exp=%b", i, level_out, (i >= 6) ? 4'b0010 : 4'b0000); end
      total++; if (rise_pulse !== ((i == 7) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL press_rise c%0d got=%b exp=%b", i, rise_pulse, (i == 7) ? 4'b0010 : 4'b0000); end
      total++; if (irq_pend !== ((i >= 8) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL press_pend c%0d got=%b exp=%b", i, irq_pend, (i >= 8) ? 4'b0010 : 4'b0000); end
      total++; if (irq_any !== (i >= 8)) begin bad++; $display("FAIL press_any c%0d got=%b exp=%b", i, irq_any, (i >= 8)); end
    end
    irq_ack[1] = 1'b1;
    tick();
    irq_ack[1] = 1'b0;
    total++; if (irq_pend !== 4'b0000 || irq_any !== 1'b0) begin bad++; $display("FAIL press_ack got=%b/%b exp=0000/0", irq_pend, irq_any); end
  endtask

  task automatic test_bounce();
    int rises;
    rises = 0;
    raw_in[2] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 3) raw_in[2] = 1'b0;
      if (i == 4) raw_in[2] = 1'b1;
      if (rise_pulse[2] === 1'b1) rises++;
      total++; if (level_out !== ((i >= 10) ? 4'b0110 : 4'b0010)) begin bad++; $display("FAIL bounce_level c%0d got=%b exp=%b", i, level_out, (i >= 10) ? 4'b0110 : 4'b0010); end
      total++; if (rise_pulse !== ((i == 11) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL bounce_rise c%0d got=%b exp=%b", i, rise_pulse, (i == 11) ? 4'b0100 : 4'b0000); end
      total++; if (irq_pend !== 4'b0000) begin bad++; $display("FAIL bounce_pend c%0d got=%b exp=0000", i, irq_pend); end
    end
    total++; if (rises != 1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", rises); end
  endtask

  task automatic test_active_low();
    raw_in[0] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++; if (level_out !== ((i >= 6) ? 4'b0111 : 4'b0110)) begin bad++; $display("FAIL al_level c%0d got=%b exp=%b", i, level_out, (i >= 6) ? 4'b0111 : 4'b0110); end
      total++; if (rise_pulse !== ((i == 7) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL al_rise c%0d got=%b exp=%b", i, rise_pulse, (i == 7) ? 4'b0001 : 4'b0000); end
      total++; if (irq_pend !== 4'b0000 || irq_any !== 1'b0) begin bad++; $display("FAIL al_pend c%0d got=%b/%b exp=0000/0", i, irq_pend, irq_any); end
    end
  endtask

  task automatic test_ack_collision();
    // Release channel 1 and clear any pending bit left over from the fall.
    raw_in[1] = 1'b0;
    repeat (10) tick();
    total++; if (level_out !== 4'b0101) begin bad++; $display("FAIL coll_rel_level got=%b exp=0101", level_out); end
    irq_ack[1] = 1'b1;
    tick();
    irq_ack[1] = 1'b0;
    total++; if (irq_pend !== 4'b0000) begin bad++; $display("FAIL coll_pre_pend got=%b exp=0000", irq_pend); end
    raw_in[1] = 1'b1;
    repeat (7) tick();
    total++; if (rise_pulse !== 4'b0010 || irq_pend !== 4'b0000) begin bad++; $display("FAIL coll_rise got=%b/%b exp=0010/0000", rise_pulse, irq_pend); end
    irq_ack[1] = 1'b1;
    tick();
    total++; if (irq_pend !== 4'b0010 || irq_any !== 1'b1) begin bad++; $display("FAIL coll_setwins got=%b/%b exp=0010/1", irq_pend, irq_any); end
    total++; if (rise_pulse !== 4'b0000) begin bad++; $display("FAIL coll_rise_end got=%b exp=0000", rise_pulse); end
    tick();
    total++; if (irq_pend !== 4'b0000 || irq_any !== 1'b0) begin bad++; $display("FAIL coll_ackalone got=%b/%b exp=0000/0", irq_pend, irq_any); end
    irq_ack[1] = 1'b0;
    tick();
    total++; if (irq_pend !== 4'b0000) begin bad++; $display("FAIL coll_stay got=%b exp=0000", irq_pend); end
  endtask

  task automatic test_release_and_reset();
    logic [3:0] exp_pend;
    raw_in[1] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
`ifdef IO_COND_BOTH_EDGES_EN
      exp_pend = (i >= 8) ? 4'b0010 : 4'b0000;
`else
      exp_pend = 4'b0000;
`endif
      total++; if (level_out !== ((i >= 6) ? 4'b0101 : 4'b0111)) begin bad++; $display("FAIL rel_level c%0d got=%b exp=%b", i, level_out, (i >= 6) ? 4'b0101 : 4'b0111); end
      total++; if (fall_pulse !== ((i == 7) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL rel_fall c%0d got=%b exp=%b", i, fall_pulse, (i == 7) ? 4'b0010 : 4'b0000); end
      total++; if (rise_pulse !== 4'b0000) begin bad++; $display("FAIL rel_rise c%0d got=%b exp=0000", i, rise_pulse); end
      total++; if (irq_pend !== exp_pend) begin bad++; $display("FAIL rel_pend c%0d got=%b exp=%b", i, irq_pend, exp_pend); end
    end
    // Press channel 3 and leave it mid-count, then apply reset.
    raw_in[3] = 1'b1;
    repeat (4) tick();
    total++; if (level_out !== 4'b0101) begin bad++; $display("FAIL mid_level got=%b exp=0101", level_out); end
    rst = 1'b1;
    #1;
    total++; if (level_out !== 4'b0000 || irq_pend !== 4'b0000 || irq_any !== 1'b0) begin bad++; $display("FAIL mid_rst_clear got=%b/%b/%b exp=0000/0000/0", level_out, irq_pend, irq_any); end
    total++; if (rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000 || sys_resetn !== 1'b0) begin bad++; $display("FAIL mid_rst_misc got=%b/%b/%b exp=0000/0000/0", rise_pulse, fall_pulse, sys_resetn); end
    tick();
    rst = 1'b0;
    // Channels 0, 2 and 3 are still active and must re-qualify from zero.
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (level_out !== ((i >= 6) ? 4'b1101 : 4'b0000)) begin bad++; $display("FAIL requal_level c%0d got=%b exp=%b", i, level_out, (i >= 6) ? 4'b1101 : 4'b0000); end
      total++; if (rise_pulse !== ((i == 7) ? 4'b1101 : 4'b0000)) begin bad++; $display("FAIL requal_rise c%0d got=%b exp=%b", i, rise_pulse, (i == 7) ? 4'b1101 : 4'b0000); end
      total++; if (sys_resetn !== (i >= 2)) begin bad++; $display("FAIL requal_sysrn c%0d got=%b exp=%b", i, sys_resetn, (i >= 2)); end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    raw_in  = 4'b0001;
    irq_en  = 4'b0010;
    irq_ack = 4'b0000;
    test_reset();
    test_press();
    test_bounce();
    test_active_low();
    test_ack_collision();
    test_release_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
